// File: rtl/iter_shifter.sv
// Multi-cycle shifter: one operand shifted one bit per clock, result on a valid/ready channel.
// Same LR/AL command encoding as the single-cycle barrel shifter so the two are interchangeable.
module iter_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             LR,
  input  logic             AL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic             r_lr;
  logic             r_al;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_step;
  logic             w_accept;
  logic             w_release;
  logic             w_last_step;

  assign w_accept    = in_valid & r_in_ready;
  assign w_release   = out_ready & r_out_valid;
  assign w_last_step = (r_cnt == SHW'(1));

  // One-bit step selected by the latched mode; LR overrides AL.
  always_comb begin
    w_step = r_work;
    if (r_lr)
      w_step = {r_work[WIDTH-2:0], 1'b0};
    else if (r_al)
      w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
    else
      w_step = {1'b0, r_work[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_lr        <= 1'b0;
      r_al        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_work     <= din;
            r_cnt      <= shamt;
            r_lr       <= LR;
            r_al       <= AL;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (shamt == '0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_work <= w_step;
          r_cnt  <= r_cnt - SHW'(1);
          if (w_last_step) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          // Working register keeps the result until the next accepted request.
          if (w_release) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign dout      = r_work;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed and sweep bench for iter_shifter: results, latency, backpressure and reset abort.
module tb_iter_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [2:0] shamt;
  logic       lr;
  logic       al;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  iter_shifter #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .shamt(shamt), .LR(lr), .AL(al),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Drive a request (caller is at posedge+1 in IDLE), wait for the result,
  // optionally stall the consumer, then complete the result handshake.
  task automatic run_op(input logic [7:0] d, input logic [2:0] s, input logic l,
                        input logic a, input int ready_delay,
                        output logic [7:0] res, output int lat, output bit timeout);
    din = d; shamt = s; lr = l; al = a; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    din = ~d; shamt = ~s; lr = ~l; al = ~a;
    lat = 0;
    timeout = 1'b0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) timeout = 1'b1;
    repeat (ready_delay) begin
      @(posedge clk); #1;
    end
    res = dout;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
    end
    n_tests++;
    if (dout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dout: got %h want 00", dout);
    end
  endtask

  task automatic test_left();
    logic [7:0] res; int lat; bit to;
    run_op(8'b1001_0110, 3'd3, 1'b1, 1'b0, 0, res, lat, to);
    n_tests++;
    if (to || lat != 3) begin
      n_fail++;
      $display("FAIL left_latency: got %0d (timeout=%0d) want 3", lat, to);
    end
    n_tests++;
    if (res !== 8'b1011_0000) begin
      n_fail++;
      $display("FAIL left_result: got %b want 10110000", res);
    end
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL left_idle_after: got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_right();
    logic [7:0] res; int lat; bit to;
    run_op(8'b1001_0110, 3'd2, 1'b0, 1'b1, 0, res, lat, to);
    n_tests++;
    if (to || res !== 8'b1110_0101) begin
      n_fail++;
      $display("FAIL ars_2: got %b want 11100101", res);
    end
    run_op(8'b1001_0110, 3'd7, 1'b0, 1'b0, 0, res, lat, to);
    n_tests++;
    if (to || res !== 8'b0000_0001 || lat != 7) begin
      n_fail++;
      $display("FAIL lrs_7: got %b lat %0d want 00000001 lat 7", res, lat);
    end
    run_op(8'h7F, 3'd7, 1'b0, 1'b1, 0, res, lat, to);
    n_tests++;
    if (to || res !== 8'h00) begin
      n_fail++;
      $display("FAIL ars_7f_7: got %h want 00", res);
    end
  endtask

  task automatic test_zero_and_precedence();
    logic [7:0] res; int lat; bit to;
    run_op(8'hA5, 3'd0, 1'b0, 1'b1, 0, res, lat, to);
    n_tests++;
    if (to || lat != 0 || res !== 8'hA5) begin
      n_fail++;
      $display("FAIL zero_shift: got %h lat %0d want a5 lat 0", res, lat);
    end
    run_op(8'h81, 3'd1, 1'b1, 1'b1, 0, res, lat, to);
    n_tests++;
    if (to || res !== 8'h02) begin
      n_fail++;
      $display("FAIL lr_precedence: got %h want 02", res);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    din = 8'h3C; shamt = 3'd2; lr = 1'b1; al = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (!out_valid || dout !== 8'hF0) begin
      n_fail++;
      $display("FAIL bp_result: got vld=%b dout=%h want 1 f0", out_valid, dout);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      din = 8'(i * 37);
      shamt = 3'(i);
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || dout !== 8'hF0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got vld=%b dout=%h rdy=%b busy=%b want 1 f0 0 1",
                 i, out_valid, dout, in_ready, busy);
      end
    end
    // Request and result handshake together: only the result handshake happens.
    in_valid = 1'b1; din = 8'h11; shamt = 3'd1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || dout !== 8'hF0) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b vld=%b busy=%b dout=%h want 1 0 0 f0",
               in_ready, out_valid, busy, dout);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res; int lat; bit to; bit seen;
    din = 8'hFF; shamt = 3'd7; lr = 1'b1; al = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if ({in_ready, out_valid, busy} !== 3'b100 || dout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: got rdy/vld/busy=%b dout=%h want 100 00",
               {in_ready, out_valid, busy}, dout);
    end
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_no_pulse: got out_valid=1 after abort want 0");
    end
    run_op(8'hC3, 3'd4, 1'b0, 1'b1, 1, res, lat, to);
    n_tests++;
    if (to || res !== 8'hFC || lat != 4) begin
      n_fail++;
      $display("FAIL reset_fresh: got %h lat %0d want fc lat 4", res, lat);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] res, exp_v;
    logic signed [7:0] sd;
    int lat; bit to;
    for (int m = 0; m < 3; m++) begin
      for (int d = 0; d < 256; d++) begin
        for (int s = 0; s < 8; s++) begin
          sd = 8'(d);
          case (m)
            0:       exp_v = 8'(d << s);
            1:       exp_v = 8'(d >> s);
            default: exp_v = 8'(sd >>> s);
          endcase
          if ($urandom_range(1, 0) == 1) begin
            @(posedge clk); #1;
          end
          run_op(8'(d), 3'(s), (m == 0), (m == 2), int'($urandom_range(1, 0)), res, lat, to);
          n_tests++;
          if (to || lat != s || res !== exp_v) begin
            n_fail++;
            $display("FAIL sweep m%0d d%h s%0d: got %h lat %0d want %h lat %0d",
                     m, d, s, res, lat, exp_v, s);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    din = '0; shamt = '0; lr = 1'b0; al = 1'b0;
    test_reset();
    test_left();
    test_right();
    test_zero_and_precedence();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
